// File: rtl/usb_txn_sequencer.sv
// Host-side USB transaction sequencer: runs READ/WRITE transactions as an
// address phase followed by a data phase, with bounded retry and timeout.
module usb_txn_sequencer #(
  parameter int         MAX_RETRY = 8,
  parameter int         TIMEOUT   = 255,
  parameter logic [3:0] ENDP_ADDR = 4'd4,
  parameter logic [3:0] ENDP_DATA = 4'd8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_read,
  input  logic        start_write,
  input  logic [15:0] mempage,
  input  logic [63:0] wdata,
  output logic        send_OUT,
  output logic        send_IN,
  output logic        send_DATA0,
  output logic        send_ACK,
  output logic        send_NAK,
  output logic [3:0]  endp,
  output logic [63:0] data,
  input  logic        out_done,
  input  logic        rx_done,
  input  logic        rx_ACK,
  input  logic        rx_NAK,
  input  logic        rx_DATA0,
  input  logic        rx_crc_ok,
  input  logic [63:0] rx_data,
  output logic        busy,
  output logic        done,
  output logic        success,
  output logic [63:0] rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE,
    A_TOK,
    A_TOKW,
    A_DAT,
    A_DATW,
    A_HSW,
    B_TOK,
    B_TOKW,
    B_DAT,
    B_DATW,
    B_RXW,
    B_REPLY,
    B_REPLYW,
    FIN
  } state_t;

  state_t        r_state;
  logic          r_write;
  logic [15:0]   r_page;
  logic [63:0]   r_wdata;
  logic [3:0]    r_retry;
  logic [TW-1:0] r_to;
  logic          r_reply_ack;

  logic [3:0]    w_retry_inc;
  logic          w_retry_fail;
  logic          w_timeout;
  logic          w_rx_ack;
  logic          w_wait;

  assign w_retry_inc  = (r_retry == 4'(MAX_RETRY)) ? r_retry
                                                   : r_retry + 4'd1;
  assign w_retry_fail = (w_retry_inc == 4'(MAX_RETRY));
  assign w_timeout    = (r_to == TW'(TIMEOUT - 1));
  // A packet flagged both ACK and NAK is malformed and never counts as ACK.
  assign w_rx_ack     = rx_done && rx_ACK && !rx_NAK;
  assign w_wait       = (r_state == A_HSW) || (r_state == B_RXW);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_to <= '0;
    end else if (out_done) begin
      r_to <= '0;
    end else if (w_wait) begin
      r_to <= r_to + TW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_page      <= '0;
      r_wdata     <= '0;
      r_retry     <= '0;
      r_reply_ack <= 1'b0;
      send_OUT    <= 1'b0;
      send_IN     <= 1'b0;
      send_DATA0  <= 1'b0;
      send_ACK    <= 1'b0;
      send_NAK    <= 1'b0;
      endp        <= '0;
      data        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      success     <= 1'b0;
      rdata       <= '0;
    end else begin
      send_OUT   <= 1'b0;
      send_IN    <= 1'b0;
      send_DATA0 <= 1'b0;
      send_ACK   <= 1'b0;
      send_NAK   <= 1'b0;
      done       <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_write || start_read) begin
            r_write  <= start_write;
            r_page   <= mempage;
            r_wdata  <= wdata;
            r_retry  <= '0;
            busy     <= 1'b1;
            success  <= 1'b0;
            send_OUT <= 1'b1;
            endp     <= ENDP_ADDR;
            r_state  <= A_TOK;
          end
        end
        A_TOK: r_state <= A_TOKW;
        A_TOKW: begin
          if (out_done) begin
            send_DATA0 <= 1'b1;
            data       <= {r_page, 48'h0};
            r_state    <= A_DAT;
          end
        end
        A_DAT: r_state <= A_DATW;
        A_DATW: begin
          if (out_done) r_state <= A_HSW;
        end
        A_HSW: begin
          if (w_rx_ack) begin
            r_retry  <= '0;
            send_OUT <= r_write;
            send_IN  <= !r_write;
            endp     <= ENDP_DATA;
            r_state  <= B_TOK;
          end else if (rx_done || w_timeout) begin
            r_retry <= w_retry_inc;
            if (w_retry_fail) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              success <= 1'b0;
              r_state <= FIN;
            end else begin
              send_OUT <= 1'b1;
              endp     <= ENDP_ADDR;
              r_state  <= A_TOK;
            end
          end
        end
        B_TOK: r_state <= B_TOKW;
        B_TOKW: begin
          if (out_done) begin
            if (r_write) begin
              send_DATA0 <= 1'b1;
              data       <= r_wdata;
              r_state    <= B_DAT;
            end else begin
              r_state <= B_RXW;
            end
          end
        end
        B_DAT: r_state <= B_DATW;
        B_DATW: begin
          if (out_done) r_state <= B_RXW;
        end
        B_RXW: begin
          if (r_write && w_rx_ack) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            success <= 1'b1;
            r_state <= FIN;
          end else if (!r_write && rx_done && rx_DATA0) begin
            // Good CRC is acknowledged; a corrupt payload is NAKed and retried.
            if (rx_crc_ok) rdata <= rx_data;
            r_reply_ack <= rx_crc_ok;
            send_ACK    <= rx_crc_ok;
            send_NAK    <= !rx_crc_ok;
            r_state     <= B_REPLY;
          end else if (rx_done || w_timeout) begin
            r_retry <= w_retry_inc;
            if (w_retry_fail) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              success <= 1'b0;
              r_state <= FIN;
            end else begin
              send_OUT <= r_write;
              send_IN  <= !r_write;
              endp     <= ENDP_DATA;
              r_state  <= B_TOK;
            end
          end
        end
        B_REPLY: r_state <= B_REPLYW;
        B_REPLYW: begin
          if (out_done) begin
            if (r_reply_ack) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              success <= 1'b1;
              r_state <= FIN;
            end else begin
              r_retry <= w_retry_inc;
              if (w_retry_fail) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                success <= 1'b0;
                r_state <= FIN;
              end else begin
                send_IN <= 1'b1;
                endp    <= ENDP_DATA;
                r_state <= B_TOK;
              end
            end
          end
        end
        FIN: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
